zap_wb_sram_ctrl: RTL

ZAP_WB_SRAM_CTRL -- requirements
Module: zap_wb_sram_ctrl

---
 rtl/zap_wb_sram_ctrl.sv | 133 +++++++++++++
 1 files changed

// File: rtl/zap_wb_sram_ctrl.sv
// Wishbone slave bridging single-beat and burst accesses onto a synchronous SRAM port.
// One SRAM strobe per accepted beat; out-of-window or unsupported cycle types answer with err.
module zap_wb_sram_ctrl #(
    parameter int          DEPTH       = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0,
    parameter int          WAIT_STATES = 0
) (
    input  logic                     i_clk,
    input  logic                     i_reset_n,
    input  logic                     i_wb_cyc,
    input  logic                     i_wb_stb,
    input  logic                     i_wb_wen,
    input  logic [3:0]               i_wb_sel,
    input  logic [31:0]              i_wb_dat,
    input  logic [31:0]              i_wb_adr,
    input  logic [2:0]               i_wb_cti,
    output logic                     o_wb_ack,
    output logic                     o_wb_err,
    output logic [31:0]              o_wb_dat,
    output logic                     o_sram_ce,
    output logic                     o_sram_we,
    output logic [3:0]               o_sram_be,
    output logic [$clog2(DEPTH)-1:0] o_sram_adr,
    output logic [31:0]              o_sram_wdata,
    input  logic [31:0]              i_sram_rdata
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCESS  = 2'd1,
        CAPTURE = 2'd2,
        RESP    = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q,   cnt_d;
    logic            err_q,   err_d;
    logic            wen_q,   wen_d;
    logic [3:0]      sel_q,   sel_d;
    logic [31:0]     dat_q,   dat_d;
    logic [AW-1:0]   adr_q,   adr_d;
    logic [31:0]     rdat_q,  rdat_d;

    logic            cti_ok;
    logic            req_valid;
    logic            unused_adr_lsb;

    // Byte-lane bits of the address carry no meaning for a word-wide SRAM.
    assign unused_adr_lsb = ^i_wb_adr[1:0];

    assign cti_ok    = (i_wb_cti == 3'b000) || (i_wb_cti == 3'b010) || (i_wb_cti == 3'b111);
    assign req_valid = (i_wb_adr[31:AW+2] == BASE_ADDR[31:AW+2]) && cti_ok;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        wen_d   = wen_q;
        sel_d   = sel_q;
        dat_d   = dat_q;
        adr_d   = adr_q;
        rdat_d  = rdat_q;

        case (state_q)
            IDLE: begin
                if (i_wb_cyc && i_wb_stb) begin
                    wen_d   = i_wb_wen;
                    sel_d   = i_wb_sel;
                    dat_d   = i_wb_dat;
                    adr_d   = i_wb_adr[AW+1:2];
                    err_d   = !req_valid;
                    state_d = req_valid ? ACCESS : RESP;
                end
            end
            ACCESS: begin
                cnt_d   = CW'(WAIT_STATES);
                state_d = CAPTURE;
            end
            CAPTURE: begin
                // The SRAM keeps running even if the master walks away; only the response is gated.
                if (cnt_q == '0) begin
                    if (!wen_q) begin
                        rdat_d = i_sram_rdata;
                    end
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            wen_q   <= 1'b0;
            sel_q   <= '0;
            dat_q   <= '0;
            adr_q   <= '0;
            rdat_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            wen_q   <= wen_d;
            sel_q   <= sel_d;
            dat_q   <= dat_d;
            adr_q   <= adr_d;
            rdat_q  <= rdat_d;
        end
    end

    assign o_wb_ack     = (state_q == RESP) && i_wb_cyc && !err_q;
    assign o_wb_err     = (state_q == RESP) && i_wb_cyc && err_q;
    assign o_wb_dat     = rdat_q;
    assign o_sram_ce    = (state_q == ACCESS);
    assign o_sram_we    = (state_q == ACCESS) && wen_q;
    assign o_sram_be    = sel_q;
    assign o_sram_adr   = adr_q;
    assign o_sram_wdata = dat_q;

endmodule
